// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_port_arbiter
// Description : Shares one RAM port between instruction fetch and data
//               accesses. Data has priority; a streak counter forces a fetch
//               after MAX_DSTREAK consecutive data grants with a fetch pending.
//               Optional performance counters: define MEM_ARB_PERF_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_port_arbiter #(
    parameter int MAX_DSTREAK = 4,
    parameter int AW          = 32,
    parameter int DW          = 32
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          iREN,
    input  logic [AW-1:0] iaddr,
    output logic [DW-1:0] iload,
    output logic          ihit,
    input  logic          dREN,
    input  logic          dWEN,
    input  logic [AW-1:0] daddr,
    input  logic [DW-1:0] dstore,
    output logic [DW-1:0] dload,
    output logic          dhit,
    input  logic          halt,
    output logic          ramREN,
    output logic          ramWEN,
    output logic [AW-1:0] ramaddr,
    output logic [DW-1:0] ramstore,
    input  logic [DW-1:0] ramload,
    input  logic          ram_ready,
    output logic          halted
`ifdef MEM_ARB_PERF_EN
    ,
    output logic [31:0]   icycles_stalled,
    output logic [31:0]   dcycles_stalled,
    output logic [31:0]   forced_fetches
`endif
);

    localparam int c_SW = $clog2(MAX_DSTREAK + 1);
    localparam logic [c_SW-1:0] c_STREAK_MAX = c_SW'(MAX_DSTREAK);

    localparam logic [2:0] c_IDLE   = 3'd0;
    localparam logic [2:0] c_IREAD  = 3'd1;
    localparam logic [2:0] c_DREAD  = 3'd2;
    localparam logic [2:0] c_DWRITE = 3'd3;
    localparam logic [2:0] c_HALTED = 3'd4;

    logic [2:0]      r_state;
    logic [2:0]      w_state_next;
    logic [c_SW-1:0] r_streak;
    logic            w_data_req;
    logic            w_data_ok;
    logic            w_in_data;
    logic            w_ihit;
    logic            w_dhit;

    // Request qualification and completion detection; a hit is never issued
    // in a reset cycle so an aborted access cannot look complete.
    always_comb begin
        w_data_req = dREN | dWEN;
        w_data_ok  = (r_streak < c_STREAK_MAX) || !iREN;
        w_in_data  = (r_state == c_DREAD) || (r_state == c_DWRITE);
        w_ihit     = (r_state == c_IREAD) && ram_ready && !RST;
        w_dhit     = w_in_data && ram_ready && !RST;
    end

    // Next-state selection: halt first, then writes, reads, and finally fetch.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_IDLE: begin
                if (halt)
                    w_state_next = c_HALTED;
                else if (dWEN && w_data_ok)
                    w_state_next = c_DWRITE;
                else if (dREN && w_data_ok)
                    w_state_next = c_DREAD;
                else if (iREN)
                    w_state_next = c_IREAD;
            end
            c_IREAD, c_DREAD, c_DWRITE: begin
                if (ram_ready)
                    w_state_next = c_IDLE;
            end
            c_HALTED: w_state_next = c_HALTED;
            default:  w_state_next = c_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge CLK) begin
        if (RST)
            r_state <= c_IDLE;
        else
            r_state <= w_state_next;
    end

    // Consecutive data-grant streak while a fetch waits; saturates at the limit.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_streak <= '0;
        end else if (w_ihit) begin
            r_streak <= '0;
        end else if (w_dhit) begin
            if (!iREN)
                r_streak <= '0;
            else if (r_streak < c_STREAK_MAX)
                r_streak <= r_streak + c_SW'(1);
        end
    end

    // RAM controls and hit responses decoded from the current state.
    always_comb begin
        ramREN   = (r_state == c_IREAD) || (r_state == c_DREAD);
        ramWEN   = (r_state == c_DWRITE);
        ramaddr  = (r_state == c_IREAD) ? iaddr : (w_in_data ? daddr : '0);
        ramstore = (r_state == c_DWRITE) ? dstore : '0;
        ihit     = w_ihit;
        dhit     = w_dhit;
        iload    = w_ihit ? ramload : '0;
        dload    = (w_dhit && (r_state == c_DREAD)) ? ramload : '0;
        halted   = (r_state == c_HALTED);
    end

`ifdef MEM_ARB_PERF_EN
    logic [31:0] r_icyc;
    logic [31:0] r_dcyc;
    logic [31:0] r_forced;
    logic        w_force;

    // A fetch grant is forced when data was waiting but the streak blocked it.
    always_comb begin
        w_force = (r_state == c_IDLE) && !halt && iREN && w_data_req && !w_data_ok;
    end

    // Stall and forced-fetch counters; wrap naturally at 2^32.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_icyc   <= '0;
            r_dcyc   <= '0;
            r_forced <= '0;
        end else begin
            if (iREN && !w_ihit)
                r_icyc <= r_icyc + 32'd1;
            if (w_data_req && !w_dhit)
                r_dcyc <= r_dcyc + 32'd1;
            if (w_force)
                r_forced <= r_forced + 32'd1;
        end
    end

    assign icycles_stalled = r_icyc;
    assign dcycles_stalled = r_dcyc;
    assign forced_fetches  = r_forced;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_port_arbiter
// Description : Self-checking bench for mem_port_arbiter: directed scenarios
//               followed by randomized requesters, checked every cycle
//               against a port-ownership reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_port_arbiter;

    localparam int MAXS = 4;

    logic        CLK = 1'b0;
    logic        RST;
    logic        iREN, dREN, dWEN, halt, ram_ready;
    logic [31:0] iaddr, daddr, dstore, ramload;
    logic [31:0] iload, dload, ramaddr, ramstore;
    logic        ihit, dhit, ramREN, ramWEN, halted;
`ifdef MEM_ARB_PERF_EN
    logic [31:0] icycles_stalled, dcycles_stalled, forced_fetches;
`endif

    always #5 CLK = ~CLK;

    mem_port_arbiter #(.MAX_DSTREAK(MAXS), .AW(32), .DW(32)) dut (
        .CLK(CLK), .RST(RST),
        .iREN(iREN), .iaddr(iaddr), .iload(iload), .ihit(ihit),
        .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
        .dload(dload), .dhit(dhit), .halt(halt),
        .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr),
        .ramstore(ramstore), .ramload(ramload), .ram_ready(ram_ready),
        .halted(halted)
`ifdef MEM_ARB_PERF_EN
        ,
        .icycles_stalled(icycles_stalled),
        .dcycles_stalled(dcycles_stalled),
        .forced_fetches(forced_fetches)
`endif
    );

    int errors = 0;
    int checks = 0;

    // Reference model: who owns the RAM port (0 nobody, 1 fetch, 2 data read,
    // 3 data write), whether the arbiter is parked, and the data streak.
    int          m_owner;
    bit          m_parked;
    int          m_streak;
    logic [31:0] m_icyc, m_dcyc, m_forced;
    bit          last_ihit, last_dhit;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Compare all outputs with the model for this cycle, then advance the model
    // across the next rising edge.
    task automatic tick();
        bit          e_ihit, e_dhit, e_ren, e_wen, forced;
        logic [31:0] e_addr, e_store, e_iload, e_dload;
        int          n_owner, n_streak;
        bit          n_parked;
        e_ren   = (m_owner == 1) || (m_owner == 2);
        e_wen   = (m_owner == 3);
        e_addr  = (m_owner == 1) ? iaddr : ((m_owner >= 2) ? daddr : 32'd0);
        e_store = (m_owner == 3) ? dstore : 32'd0;
        e_ihit  = (m_owner == 1) && ram_ready && !RST;
        e_dhit  = (m_owner >= 2) && ram_ready && !RST;
        e_iload = e_ihit ? ramload : 32'd0;
        e_dload = (e_dhit && m_owner == 2) ? ramload : 32'd0;
        chk("ramREN", ramREN, e_ren);
        chk("ramWEN", ramWEN, e_wen);
        chk("ramaddr", ramaddr, e_addr);
        chk("ramstore", ramstore, e_store);
        chk("ihit", ihit, e_ihit);
        chk("dhit", dhit, e_dhit);
        chk("iload", iload, e_iload);
        chk("dload", dload, e_dload);
        chk("halted", halted, m_parked);
`ifdef MEM_ARB_PERF_EN
        chk("icycles_stalled", icycles_stalled, m_icyc);
        chk("dcycles_stalled", dcycles_stalled, m_dcyc);
        chk("forced_fetches", forced_fetches, m_forced);
`endif
        n_owner  = m_owner;
        n_parked = m_parked;
        n_streak = m_streak;
        forced   = 1'b0;
        if (RST) begin
            n_owner = 0; n_parked = 0; n_streak = 0;
        end else if (m_parked) begin
            n_owner = 0;
        end else if (m_owner != 0) begin
            if (ram_ready) begin
                n_owner = 0;
                if (e_ihit)     n_streak = 0;
                else if (iREN)  n_streak = (m_streak < MAXS) ? m_streak + 1 : MAXS;
                else            n_streak = 0;
            end
        end else if (halt) begin
            n_parked = 1;
        end else if ((dREN || dWEN) && (m_streak < MAXS || !iREN)) begin
            n_owner = dWEN ? 3 : 2;
        end else if (iREN) begin
            n_owner = 1;
            forced  = dREN || dWEN;
        end
        last_ihit = e_ihit;
        last_dhit = e_dhit;
        @(posedge CLK);
        #1;
        if (RST) begin
            m_icyc = 0; m_dcyc = 0; m_forced = 0;
        end else begin
            m_icyc   = m_icyc + ((iREN && !e_ihit) ? 1 : 0);
            m_dcyc   = m_dcyc + (((dREN || dWEN) && !e_dhit) ? 1 : 0);
            m_forced = m_forced + (forced ? 1 : 0);
        end
        m_owner  = n_owner;
        m_parked = n_parked;
        m_streak = n_streak;
    endtask

    task automatic go();
        #1;
        tick();
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int          nd, nw;
        bit          got_i, i_pend, d_pend;
        int          kind;
        logic [31:0] f0;

        RST = 1; iREN = 0; dREN = 0; dWEN = 0; halt = 0; ram_ready = 0;
        iaddr = 0; daddr = 0; dstore = 0; ramload = 0;
        @(posedge CLK); @(posedge CLK); #1;
        m_owner = 0; m_parked = 0; m_streak = 0;
        m_icyc = 0; m_dcyc = 0; m_forced = 0;
        last_ihit = 0; last_dhit = 0;

        // Reset state: everything quiet.
        go();
        RST = 0;
        go();

        // Single fetch, minimum latency.
        iREN = 1; iaddr = 32'h40; ram_ready = 1; ramload = 32'hDEADBEEF;
        #1; chk("fetch_idle_ramREN", ramREN, 0); tick();
        #1; chk("fetch_ramREN", ramREN, 1); chk("fetch_ihit", ihit, 1);
        chk("fetch_iload", iload, 32'hDEADBEEF); tick();
        iREN = 0;
        go();

        // Data and fetch together: data first, then fetch.
        iREN = 1; dREN = 1; daddr = 32'h100; iaddr = 32'h44; ramload = 32'hA5A5_0001;
        go();
        #1; chk("prio_dhit", dhit, 1); chk("prio_addr", ramaddr, 32'h100);
        chk("prio_no_ihit", ihit, 0); chk("prio_dload", dload, 32'hA5A5_0001); tick();
        dREN = 0;
        go();
        #1; chk("prio_fetch_ihit", ihit, 1); chk("prio_fetch_addr", ramaddr, 32'h44); tick();
        iREN = 0;
        go();

        // Write+read collision with delayed ready.
        dWEN = 1; dREN = 1; dstore = 32'h1234; daddr = 32'h200; ram_ready = 0;
        nd = 0; nw = 0;
        go();
        for (int k = 0; k < 5; k++) begin
            ram_ready = (k == 3);
            #1;
            if (ramWEN === 1'b1) nw++;
            if (dhit === 1'b1) nd++;
            chk("wr_ramstore", ramstore, (k < 4) ? 32'h1234 : 32'h0);
            tick();
            if (k == 3) begin dWEN = 0; dREN = 0; end
        end
        chk("wr_ramWEN_cycles", nw, 4);
        chk("wr_dhit_count", nd, 1);

        // Streak limit: continuous data requests with a fetch held.
        dREN = 1; iREN = 1; daddr = 32'h300; iaddr = 32'h48; ram_ready = 1;
        nd = 0; got_i = 0;
`ifdef MEM_ARB_PERF_EN
        f0 = forced_fetches;
`else
        f0 = 0;
`endif
        for (int k = 0; k < 30 && !got_i; k++) begin
            #1;
            if (dhit === 1'b1) nd++;
            if (ihit === 1'b1) got_i = 1;
            tick();
        end
        chk("streak_forced_ihit", got_i, 1);
        chk("streak_dhits_before_fetch", nd, MAXS);
`ifdef MEM_ARB_PERF_EN
        chk("streak_forced_count", forced_fetches - f0, 1);
`endif
        // After the forced fetch the streak is clear: data wins again.
        go();
        #1; chk("streak_cleared_dhit", dhit, 1); tick();
        dREN = 0; iREN = 0;
        go();

        // Halt during a stalled data read: access completes, then park.
        dREN = 1; daddr = 32'h500; ram_ready = 0;
        go();
        halt = 1;
        #1; chk("halt_access_ramREN", ramREN, 1); chk("halt_no_dhit", dhit, 0); tick();
        #1; chk("halt_still_waiting", dhit, 0); tick();
        ram_ready = 1;
        #1; chk("halt_access_dhit", dhit, 1); tick();
        dREN = 0;
        go();
        halt = 0; iREN = 1;
        for (int k = 0; k < 4; k++) begin
            #1; chk("halted_flag", halted, 1); chk("halted_no_ramREN", ramREN, 0); tick();
        end

        // Reset in the middle of a fetch.
        RST = 1; iREN = 0;
        go();
        RST = 0; iREN = 1; iaddr = 32'h80; ram_ready = 0;
        go();
        #1; chk("rst_fetch_ramREN", ramREN, 1); tick();
        RST = 1;
        #1; chk("rst_no_ihit", ihit, 0); tick();
        RST = 0; iREN = 0;
        #1; chk("rst_after_ramREN", ramREN, 0); chk("rst_after_addr", ramaddr, 0);
        chk("rst_after_halted", halted, 0); tick();

        // Randomized requesters obeying the hold-until-hit protocol.
        i_pend = 0; d_pend = 0;
        for (int c = 0; c < 600; c++) begin
            if (last_ihit) i_pend = 0;
            if (last_dhit) d_pend = 0;
            if (!i_pend && $urandom_range(0, 2) == 0) begin
                i_pend = 1; iaddr = $urandom;
            end
            if (!d_pend && $urandom_range(0, 2) != 0) begin
                d_pend = 1; daddr = $urandom; dstore = $urandom;
                kind = $urandom_range(0, 2);
                dREN = (kind != 1);
                dWEN = (kind != 0);
            end
            iREN = i_pend;
            if (!d_pend) begin dREN = 0; dWEN = 0; end
            ram_ready = $urandom_range(0, 1);
            ramload   = $urandom;
            halt      = ($urandom_range(0, 199) == 0);
            RST       = ($urandom_range(0, 49) == 0);
            go();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Sequences the single shared RAM port between instruction fetch and the data accesses issued by the execute/memory stages (the dREN/dWEN pair carried down the pipe).
- Registered FSM grants one requester at a time and drives RAM controls from state.
- Returns one-cycle ihit/dhit pulses that the pipeline latches use as their advance and stall qualifiers.
- Data accesses take priority; a streak counter bounds instruction-fetch starvation.

Parameters:
- MAX_DSTREAK, 4: maximum consecutive data grants while iREN is pending before fetch is forced.
- AW, 32: address width.
- DW, 32: data width (word_t).

Ports:
- CLK  in  1  clock, rising edge
- RST  in  1  synchronous, active-high reset
- iREN  in  1  instruction read request, held until ihit
- iaddr  in  AW  fetch address
- iload  out  DW  fetch data, valid in the ihit cycle
- ihit  out  1  fetch complete, one-cycle pulse
- dREN  in  1  data read request, held until dhit
- dWEN  in  1  data write request, held until dhit
- daddr  in  AW  data address
- dstore  in  DW  write data
- dload  out  DW  read data, valid in the dhit cycle
- dhit  out  1  data access complete, one-cycle pulse
- halt  in  1  pipeline halt observed, level
- ramREN  out  1  RAM read strobe
- ramWEN  out  1  RAM write strobe
- ramaddr  out  AW  RAM address
- ramstore  out  DW  RAM write data
- ramload  in  DW  RAM read data
- ram_ready  in  1  RAM completes the current access this cycle
- halted  out  1  arbiter parked after halt

Behaviour:
- Reset and timing:
  - Clock is CLK. Reset is RST, synchronous and active-high.
  - On reset: state=IDLE, streak=0, and all outputs are 0 (ihit, dhit, ramREN, ramWEN, ramaddr, ramstore, iload, dload, halted).
- States: IDLE, IREAD, DREAD, DWRITE, HALTED.
- Transitions from IDLE (evaluated each cycle, next state registered):
  - halt=1 -> HALTED. halt takes precedence over all pending requests.
  - else dWEN=1 and (streak<MAX_DSTREAK or iREN=0) -> DWRITE.
  - else dREN=1 and (streak<MAX_DSTREAK or iREN=0) -> DREAD.
  - else iREN=1 -> IREAD.
  - else stay in IDLE.
- Simultaneous dREN and dWEN: the request is treated as a write.
- Access states:
  - ramREN=1 in IREAD and DREAD. ramWEN=1 in DWRITE.
  - ramaddr = iaddr in IREAD, daddr in DREAD/DWRITE, 0 otherwise.
  - ramstore = dstore in DWRITE, 0 otherwise.
- Completion:
  - In an access state with ram_ready=1: pulse ihit (IREAD) or dhit (DREAD/DWRITE) for that same cycle, then return to IDLE.
  - iload=ramload during ihit; dload=ramload during a DREAD dhit. Both are 0 otherwise.
  - With ram_ready=0, stay in the access state with outputs stable.
  - Minimum latency from request to hit is 2 cycles: 1 cycle of IDLE grant, then ram_ready in the first access cycle.
- Streak counter:
  - Increments on each data completion while iREN=1; saturates at MAX_DSTREAK.
  - Clears on an ihit, or on a data completion with iREN=0.
- Request rules:
  - A request that drops mid-access does not abort it. The access completes and the hit still pulses.
  - The requester must hold its address and data stable until its hit.
- HALTED:
  - halted=1. No RAM strobes. Ignores all requests.
  - Exits only on RST.
  - halt asserted during an access takes effect only after that access completes and the FSM reaches IDLE.
- Reset mid-access: the FSM returns to IDLE next cycle, strobes drop, and no hit is issued.

Optional Feature:
- Macro MEM_ARB_PERF_EN.
- When defined, adds three 32-bit outputs:
  - icycles_stalled: cycles with iREN=1 and no ihit.
  - dcycles_stalled: cycles with (dREN|dWEN)=1 and no dhit.
  - forced_fetches: IDLE grants to IREAD caused by streak=MAX_DSTREAK.
- All three clear on RST and wrap at 2^32.
- When undefined: these ports and their counters do not exist, and FSM behaviour is identical.

Test Plan:
- Reset, then iREN=1, iaddr=0x40, ram_ready high from the first access cycle, ramload=0xDEADBEEF -> ramREN=1 for 1 cycle; ihit with iload=0xDEADBEEF in cycle 2.
- iREN=1 and dREN=1 together, daddr=0x100 -> DREAD granted first and dhit pulses; the fetch is granted on the next IDLE.
- dWEN=1 and dREN=1, dstore=0x1234, ram_ready delayed 3 cycles -> DWRITE with ramWEN held 4 cycles, ramstore=0x1234, exactly one dhit.
- Continuous dREN with iREN held, MAX_DSTREAK=4 -> 4 dhits, then a forced IREAD with ihit, streak back to 0 (forced_fetches=1 when MEM_ARB_PERF_EN).
- halt asserted during a DREAD waiting on ram_ready -> the access completes with dhit, then halted=1, and subsequent iREN produces no ramREN.
- RST asserted in IREAD before ram_ready -> the next cycle is IDLE with all outputs 0 and no ihit.
